// File: rtl/ps2_line_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ps2_line_buffer
//  Purpose  : Collects ASCII characters from a PS/2 keyboard decoder into a
//             32-character, left-justified command line. Supports backspace,
//             escape and enter. Presents the completed line with a one-cycle
//             ready pulse, holds it briefly, and then clears it.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_line_buffer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [7:0]   char_in,
    input  logic         char_valid,
    output logic [255:0] input_line,
    output logic         line_ready,
    output logic [5:0]   char_count,
    output logic         overflow,
    output logic         busy
);

    // The hold counter runs from 0 to HOLD_CYCLES-1.
    localparam int              HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_ENTER = 8'h0D;
    localparam logic [7:0] CH_ESC   = 8'h1B;

    typedef enum logic [1:0] {
        EDIT  = 2'd0,
        READY = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t              state;
    // line[31] is slot 0, so the packed vector is already left-justified.
    logic [31:0][7:0]    line;
    logic [HOLD_W-1:0]   hold_cnt;

    logic                is_printable;
    logic                is_lower;
    logic [7:0]          stored_char;
    logic [4:0]          wr_slot;
    logic [4:0]          bs_slot;

    assign is_printable = (char_in >= 8'h20) && (char_in <= 8'h7E);
    assign is_lower     = (char_in >= 8'h61) && (char_in <= 8'h7A);
    assign stored_char  = is_lower ? (char_in - 8'h20) : char_in;
    // Slot k lives at line[31-k]; the write slot is char_count and the
    // backspace slot is char_count-1 (both only used in their valid ranges).
    assign wr_slot      = 5'd31 - char_count[4:0];
    assign bs_slot      = 5'd31 - (char_count[4:0] - 5'd1);

    assign input_line   = line;

    // Line editing, completion sequencing and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= EDIT;
            line       <= '0;
            char_count <= 6'd0;
            overflow   <= 1'b0;
            line_ready <= 1'b0;
            busy       <= 1'b0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                EDIT: begin
                    if (char_valid) begin
                        if (is_printable) begin
                            if (char_count < 6'd32) begin
                                line[wr_slot] <= stored_char;
                                char_count    <= char_count + 6'd1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end else if (char_in == CH_BS) begin
                            if (char_count != 6'd0) begin
                                line[bs_slot] <= 8'h00;
                                char_count    <= char_count - 6'd1;
                            end
                        end else if (char_in == CH_ESC) begin
                            line       <= '0;
                            char_count <= 6'd0;
                            overflow   <= 1'b0;
                        end else if (char_in == CH_ENTER) begin
                            if (char_count != 6'd0) begin
                                state      <= READY;
                                line_ready <= 1'b1;
                                busy       <= 1'b1;
                                hold_cnt   <= '0;
                            end
                        end
                    end
                end
                READY: begin
                    line_ready <= 1'b0;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        state    <= CLEAR;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    line       <= '0;
                    char_count <= 6'd0;
                    overflow   <= 1'b0;
                    busy       <= 1'b0;
                    state      <= EDIT;
                end
                default: begin
                    state <= EDIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_line_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_line_buffer
//  Purpose  : Self-checking bench for ps2_line_buffer with directed scenarios
//             and a randomized run against a behavioural line model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_line_buffer;

    localparam int HOLD_CYCLES = 2;

    logic         clock;
    logic         reset;
    logic [7:0]   char_in;
    logic         char_valid;
    logic [255:0] input_line;
    logic         line_ready;
    logic [5:0]   char_count;
    logic         overflow;
    logic         busy;

    int total;
    int bad;

    // Behavioural model: a line of bytes, a count, the overflow flag, and the
    // number of cycles elapsed since a line was committed (0 = editing).
    logic [7:0] m_line [32];
    int         m_cnt;
    logic       m_ovf;
    logic       m_lr;
    int         m_phase;

    ps2_line_buffer #(.HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clock      (clock),
        .reset      (reset),
        .char_in    (char_in),
        .char_valid (char_valid),
        .input_line (input_line),
        .line_ready (line_ready),
        .char_count (char_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_clear();
        for (int k = 0; k < 32; k++) m_line[k] = 8'h00;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] c);
        m_lr = 1'b0;
        if (r) begin
            model_clear();
            m_phase = 0;
        end else if (m_phase != 0) begin
            // Committed line: ready, HOLD_CYCLES of hold, one clear cycle.
            if (m_phase == HOLD_CYCLES + 2) begin
                model_clear();
                m_phase = 0;
            end else begin
                m_phase++;
            end
        end else if (v) begin
            if (c >= 8'h20 && c <= 8'h7E) begin
                if (m_cnt < 32) begin
                    m_line[m_cnt] = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
                    m_cnt++;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (c == 8'h08) begin
                if (m_cnt > 0) begin
                    m_cnt--;
                    m_line[m_cnt] = 8'h00;
                end
            end else if (c == 8'h1B) begin
                model_clear();
            end else if (c == 8'h0D) begin
                if (m_cnt > 0) begin
                    m_phase = 1;
                    m_lr    = 1'b1;
                end
            end
        end
    endtask

    function automatic logic [255:0] exp_line();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 32; k++) v[255-8*k -: 8] = m_line[k];
        return v;
    endfunction

    // One clock: apply inputs, advance the model at the edge, settle 1ns.
    task automatic tick(input logic r, input logic v, input logic [7:0] c);
        reset      = r;
        char_valid = v;
        char_in    = c;
        @(posedge clock);
        model_step(r, v, c);
        #1;
        reset      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'($urandom);
    endtask

    task automatic type_str(input string s);
        for (int i = 0; i < s.len(); i++) tick(1'b0, 1'b1, s[i]);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 8'h41);
        total++;
        if (input_line !== '0 || char_count !== 6'd0 || overflow !== 1'b0 ||
            line_ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset got line=%h cnt=%0d ovf=%b rdy=%b busy=%b want all 0",
                     input_line, char_count, overflow, line_ready, busy);
        end
    endtask

    task automatic test_fire();
        tick(1'b1, 1'b0, 8'h00);
        type_str("fire");
        tick(1'b0, 1'b1, 8'h0D);
        total++;
        if (line_ready !== 1'b1) begin
            bad++; $display("FAIL fire_ready got=%b want=1", line_ready);
        end
        total++;
        if (input_line !== {32'h46495245, 224'h0} || char_count !== 6'd4) begin
            bad++; $display("FAIL fire_line got=%h cnt=%0d want=%h cnt=4",
                            input_line, char_count, {32'h46495245, 224'h0});
        end
        for (int i = 0; i < HOLD_CYCLES; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (line_ready !== 1'b0 || busy !== 1'b1 || char_count !== 6'd4 ||
                input_line !== {32'h46495245, 224'h0}) begin
                bad++; $display("FAIL fire_hold%0d got rdy=%b busy=%b cnt=%0d line=%h want held line",
                                i, line_ready, busy, char_count, input_line);
            end
        end
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        total++;
        if (input_line !== '0 || char_count !== 6'd0 || overflow !== 1'b0 ||
            line_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL fire_cleared got line=%h cnt=%0d rdy=%b busy=%b want all 0",
                            input_line, char_count, line_ready, busy);
        end
    endtask

    task automatic test_edit();
        type_str("SET V 00120");
        tick(1'b0, 1'b1, 8'h08);
        type_str("5");
        tick(1'b0, 1'b1, 8'h0D);
        total++;
        if (line_ready !== 1'b1 || char_count !== 6'd11 ||
            input_line !== {88'h5345542056203030313235, 168'h0}) begin
            bad++; $display("FAIL edit_line got rdy=%b cnt=%0d line=%h want rdy=1 cnt=11 line=%h",
                            line_ready, char_count, input_line,
                            {88'h5345542056203030313235, 168'h0});
        end
        for (int i = 0; i < HOLD_CYCLES + 2; i++) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 34; i++) tick(1'b0, 1'b1, 8'h41);
        total++;
        if (char_count !== 6'd32 || input_line !== {32{8'h41}} || overflow !== 1'b1) begin
            bad++; $display("FAIL ovf_full got cnt=%0d ovf=%b line=%h want cnt=32 ovf=1 all 41",
                            char_count, overflow, input_line);
        end
        tick(1'b0, 1'b1, 8'h1B);
        total++;
        if (input_line !== '0 || char_count !== 6'd0 || overflow !== 1'b0 ||
            line_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL ovf_escape got line=%h cnt=%0d ovf=%b rdy=%b busy=%b want all 0",
                            input_line, char_count, overflow, line_ready, busy);
        end
    endtask

    task automatic test_empty();
        tick(1'b0, 1'b1, 8'h0D);
        total++;
        if (line_ready !== 1'b0 || busy !== 1'b0 || char_count !== 6'd0 || input_line !== '0) begin
            bad++; $display("FAIL empty_enter got rdy=%b busy=%b cnt=%0d want 0 0 0",
                            line_ready, busy, char_count);
        end
        tick(1'b0, 1'b1, 8'h08);
        total++;
        if (line_ready !== 1'b0 || busy !== 1'b0 || char_count !== 6'd0 ||
            input_line !== '0 || overflow !== 1'b0) begin
            bad++; $display("FAIL empty_bs got rdy=%b busy=%b cnt=%0d ovf=%b want all 0",
                            line_ready, busy, char_count, overflow);
        end
    endtask

    task automatic test_busy_drop();
        type_str("AB");
        tick(1'b0, 1'b1, 8'h0D);
        total++;
        if (line_ready !== 1'b1) begin
            bad++; $display("FAIL drop_ready got=%b want=1", line_ready);
        end
        // 'X' offered during READY, both HOLD cycles and CLEAR.
        for (int i = 0; i < HOLD_CYCLES + 1; i++) begin
            tick(1'b0, 1'b1, 8'h58);
            total++;
            if (input_line !== {16'h4142, 240'h0} || char_count !== 6'd2 || overflow !== 1'b0) begin
                bad++; $display("FAIL drop_held%0d got cnt=%0d ovf=%b line=%h want cnt=2 ovf=0 AB",
                                i, char_count, overflow, input_line);
            end
        end
        tick(1'b0, 1'b1, 8'h58);
        total++;
        if (input_line !== '0 || char_count !== 6'd0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL drop_clear got cnt=%0d busy=%b line=%h want empty",
                            char_count, busy, input_line);
        end
        tick(1'b0, 1'b1, 8'h58);
        total++;
        if (input_line !== {8'h58, 248'h0} || char_count !== 6'd1) begin
            bad++; $display("FAIL drop_first_edit got cnt=%0d line=%h want cnt=1 slot0=58",
                            char_count, input_line);
        end
        tick(1'b0, 1'b1, 8'h1B);
    endtask

    task automatic test_reset_hold();
        type_str("q");
        tick(1'b0, 1'b1, 8'h0D);
        tick(1'b0, 1'b0, 8'h00);
        total++;
        if (busy !== 1'b1 || line_ready !== 1'b0 || input_line !== {8'h51, 248'h0}) begin
            bad++; $display("FAIL rsthold_pre got busy=%b rdy=%b line=%h want busy=1 rdy=0 slot0=51",
                            busy, line_ready, input_line);
        end
        tick(1'b1, 1'b0, 8'h00);
        total++;
        if (input_line !== '0 || char_count !== 6'd0 || overflow !== 1'b0 ||
            line_ready !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL rsthold_reset got line=%h cnt=%0d rdy=%b busy=%b want all 0",
                            input_line, char_count, line_ready, busy);
        end
        for (int i = 0; i < HOLD_CYCLES + 3; i++) begin
            tick(1'b0, 1'b0, 8'h00);
            total++;
            if (line_ready !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rsthold_after%0d got rdy=%b busy=%b want 0 0",
                                i, line_ready, busy);
            end
        end
    endtask

    task automatic test_random();
        logic       r;
        logic       v;
        logic [7:0] c;
        int         sel;
        tick(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 4000; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            v   = ($urandom_range(0, 99) < 75);
            sel = $urandom_range(0, 99);
            if (sel < 55)      c = 8'($urandom_range(8'h20, 8'h7E));
            else if (sel < 72) c = 8'($urandom_range(8'h61, 8'h7A));
            else if (sel < 82) c = 8'h08;
            else if (sel < 84) c = 8'h1B;
            else if (sel < 88) c = 8'h0D;
            else               c = 8'($urandom);
            tick(r, v, c);
            total++;
            if (input_line !== exp_line() || char_count !== 6'(m_cnt) ||
                overflow !== m_ovf || line_ready !== m_lr ||
                busy !== (m_phase != 0)) begin
                bad++;
                $display("FAIL rand n=%0d got line=%h cnt=%0d ovf=%b rdy=%b busy=%b want line=%h cnt=%0d ovf=%b rdy=%b busy=%b",
                         n, input_line, char_count, overflow, line_ready, busy,
                         exp_line(), m_cnt, m_ovf, m_lr, (m_phase != 0));
            end
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        m_cnt      = 0;
        m_ovf      = 1'b0;
        m_lr       = 1'b0;
        m_phase    = 0;
        for (int k = 0; k < 32; k++) m_line[k] = 8'h00;
        @(negedge clock);
        test_reset();
        test_fire();
        test_edit();
        test_overflow();
        test_empty();
        test_busy_drop();
        test_reset_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_line_buffer.md
PS2_LINE_BUFFER -- requirements
Module: ps2_line_buffer

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: cycles input_line stays frozen after the line_ready pulse before the buffer clears.
REQ-002 Port clock  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port char_in  input  8  ASCII byte from the upstream PS/2 keyboard decoder.
REQ-005 Port char_valid  input  1  one-cycle strobe qualifying char_in.
REQ-006 Port input_line  output  256  32-character line, left-justified: char 0 in [255:248], char k in [255-8k:248-8k], unused slots 0x00.
REQ-007 Port line_ready  output  1  one-cycle pulse marking a completed command line.
REQ-008 Port char_count  output  6  number of characters held, 0..32.
REQ-009 Port overflow  output  1  sticky flag: a printable character was dropped because the buffer was full.
REQ-010 Port busy  output  1  high whenever state is not EDIT; characters are dropped while busy.

Function
REQ-011 States SHALL be EDIT, READY, HOLD and CLEAR; reset enters EDIT.
REQ-012 In EDIT, char_valid with char_in in 0x20..0x7E and char_count<32 SHALL write the character to slot char_count and increment char_count, both visible the next cycle.
REQ-013 Characters 0x61..0x7A SHALL be stored as the uppercase value (char_in-0x20); all other printables SHALL be stored unchanged.
REQ-014 A printable character with char_count==32 SHALL leave the line and count unchanged and set overflow.
REQ-015 Backspace (0x08) with char_count>0 SHALL zero slot char_count-1 and decrement char_count; with char_count==0 it SHALL have no effect.
REQ-016 Escape (0x1B) SHALL zero input_line, char_count and overflow next cycle without a line_ready pulse, and SHALL stay in EDIT.
REQ-017 Enter (0x0D) with char_count>0 SHALL move to READY next cycle; Enter with char_count==0 SHALL be ignored.
REQ-018 All other byte values SHALL be ignored.
REQ-019 line_ready SHALL be high for exactly the single READY cycle; READY SHALL go to HOLD.
REQ-020 HOLD SHALL last HOLD_CYCLES cycles, counted by an internal counter, then go to CLEAR.
REQ-021 From READY through HOLD, input_line and char_count SHALL be held unchanged.
REQ-022 CLEAR SHALL last one cycle; at its end input_line, char_count and overflow SHALL be zeroed and the state SHALL return to EDIT.
REQ-023 char_valid while busy SHALL be dropped with no effect on any output; overflow SHALL NOT be set.
REQ-024 Enter at cycle t SHALL give line_ready=1 at t+1, a held line over t+1..t+1+HOLD_CYCLES, CLEAR at t+2+HOLD_CYCLES, and EDIT accepting characters at t+3+HOLD_CYCLES.
REQ-025 All outputs SHALL be registered; there SHALL be no combinational path from char_in or char_valid to any output.

Reset
REQ-026 reset SHALL take priority over all other inputs in every state, including mid-HOLD.
REQ-027 Reset SHALL give input_line=0, char_count=0, overflow=0, line_ready=0, busy=0, HOLD counter=0 and state EDIT on the next cycle.

Verification
REQ-028 Type "fire" then Enter -> input_line[255:224]=0x46495245, [223:0]=0, char_count=4; line_ready high one cycle; line held 2 further cycles; all outputs zero 4 cycles after line_ready.
REQ-029 Type "SET V 00120", Backspace, "5", Enter -> line "SET V 00125" (0x5345542056203030313235 left-justified) when line_ready is high.
REQ-030 Type 34 'A' -> char_count=32, all 32 slots 0x41, overflow=1; Escape -> all outputs 0, no line_ready pulse.
REQ-031 Enter on an empty line, and Backspace at count 0 -> no line_ready, busy stays 0, all outputs unchanged.
REQ-032 Enter, then char_valid 'X' during READY and HOLD -> 'X' absent and overflow 0; 'X' sent in the first EDIT cycle -> slot 0=0x58, char_count=1.
REQ-033 Assert reset in the first HOLD cycle -> next cycle all outputs 0 and busy=0; line_ready does not pulse again.
